// File: rtl/ibus_responder_if.sv
// Instruction-bus payload types and the bundle of handshake signals around ibus_responder.
package ibus_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// Fetch-side and memory-side signals of the responder; master is the surrounding environment.
interface ibus_responder_if;
    import ibus_pkg::*;

    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        flush;
    logic        mreq_valid;
    logic [63:0] mreq_addr;
    logic        mreq_ready;
    logic        mresp_valid;
    logic [63:0] mresp_data;
    logic [15:0] timeout_cnt;

    modport master (
        output ireq, flush, mreq_ready, mresp_valid, mresp_data,
        input  iresp, mreq_valid, mreq_addr, timeout_cnt
    );

    modport slave (
        input  ireq, flush, mreq_ready, mresp_valid, mresp_data,
        output iresp, mreq_valid, mreq_addr, timeout_cnt
    );

endinterface

// File: rtl/ibus_responder.sv
// Instruction-bus target with a one-doubleword line buffer in front of a 64-bit memory port.
module ibus_responder
    import ibus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0,
    parameter logic [31:0] TO_DATA = 32'h0000_0013
) (
    input logic             clk,
    input logic             reset,
    ibus_responder_if.slave bus
);

    localparam int unsigned WAIT_W = 32;
    localparam int unsigned TAG_W  = 61;
    localparam int unsigned CNT_W  = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MREQ  = 2'd1;
    localparam logic [1:0] MWAIT = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [63:0]       cap_addr;
    logic              buf_valid;
    logic [TAG_W-1:0]  buf_tag;
    logic [63:0]       buf_data;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;
    logic              flush_pend;
    logic              drop_pend;
    logic [CNT_W-1:0]  timeout_cnt_q;

    logic              hit;
    logic              match;
    logic              mresp_take;
    logic              to_fire;
    logic              flush_any;
    ibus_resp_t        resp_c;

    assign hit        = buf_valid && (bus.ireq.addr[63:3] == buf_tag);
    assign match      = bus.ireq.valid && (bus.ireq.addr == cap_addr);
    // A response owed to a timed-out read is swallowed, never treated as fill data.
    assign mresp_take = bus.mresp_valid && !drop_pend;
    assign to_fire    = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1)) && !mresp_take;
    // A flush arriving on the fill cycle itself must also keep the fill invalid.
    assign flush_any  = flush_pend || bus.flush;

    assign bus.iresp       = resp_c;
    assign bus.mreq_valid  = (state_q == MREQ);
    assign bus.mreq_addr   = (state_q == MREQ) ? {cap_addr[63:3], 3'b000} : 64'd0;
    assign bus.timeout_cnt = timeout_cnt_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and combinational fetch response.
    always_comb begin
        state_d = state_q;
        resp_c  = '0;
        case (state_q)
            IDLE: begin
                if (bus.ireq.valid) begin
                    resp_c.addr_ok = 1'b1;
                    state_d        = hit ? RESP : MREQ;
                end
            end
            MREQ: begin
                if (bus.mreq_ready) begin
                    state_d = MWAIT;
                end
            end
            MWAIT: begin
                if (mresp_take || to_fire) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (match) begin
                    resp_c.data_ok = 1'b1;
                    resp_c.data    = timed_out ? TO_DATA
                                   : (cap_addr[2] ? buf_data[63:32] : buf_data[31:0]);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!reset) begin
            resp_c = '0;
        end
    end

    // Capture address, line buffer, wait/timeout counters and flush/drop bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_addr      <= 64'd0;
            buf_valid     <= 1'b0;
            buf_tag       <= '0;
            buf_data      <= 64'd0;
            wait_cnt      <= '0;
            timed_out     <= 1'b0;
            flush_pend    <= 1'b0;
            drop_pend     <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            if (bus.mresp_valid && drop_pend) begin
                drop_pend <= 1'b0;
            end
            if (bus.flush && (state_q != MWAIT)) begin
                buf_valid <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (bus.ireq.valid) begin
                        cap_addr  <= bus.ireq.addr;
                        timed_out <= 1'b0;
                    end
                end
                MREQ: begin
                    if (bus.mreq_ready) begin
                        wait_cnt <= '0;
                    end
                end
                MWAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (mresp_take) begin
                        buf_tag    <= cap_addr[63:3];
                        buf_data   <= bus.mresp_data;
                        buf_valid  <= !flush_any;
                        flush_pend <= 1'b0;
                    end else if (to_fire) begin
                        timed_out  <= 1'b1;
                        drop_pend  <= 1'b1;
                        flush_pend <= 1'b0;
                        if (flush_any) begin
                            buf_valid <= 1'b0;
                        end
                        if (timeout_cnt_q != {CNT_W{1'b1}}) begin
                            timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
                        end
                    end else if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
